// File: rtl/data_cache_controller_if.sv
// Bundle of the MEM-stage request/response signals and the main-memory port
// of the data cache. The cache uses the slave view; the pipeline/memory side uses master.
interface data_cache_controller_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        hit;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_ready;

  // Handshake: a memory request (mem_read or mem_write) and its mem_address /
  // mem_write_data hold steady until a cycle where mem_ready is high; that
  // cycle completes the word. The CPU side holds its inputs while hit is 0.
  modport slave (
    input  MemRead, MemWrite, address, write_data, mem_read_data, mem_ready,
    output read_data, hit, mem_read, mem_write, mem_address, mem_write_data
  );

  modport master (
    output MemRead, MemWrite, address, write_data, mem_read_data, mem_ready,
    input  read_data, hit, mem_read, mem_write, mem_address, mem_write_data
  );
endinterface

// File: rtl/data_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache between the
// EX/MEM register and main memory; hit=0 stalls the pipeline.
module data_cache_controller #(
  parameter int INDEX_BITS  = 4,
  parameter int OFFSET_BITS = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  data_cache_controller_if.slave cache_bus,
  output logic [1:0]            o_state
);

  localparam int TAG_BITS = 32 - 2 - OFFSET_BITS - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << OFFSET_BITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [OFFSET_BITS-1:0] r_count;
  logic [LINES-1:0]       r_valid;
  logic [TAG_BITS-1:0]    r_tag  [LINES];
  logic [31:0]            r_data [LINES*WORDS];

  logic [OFFSET_BITS-1:0] w_offset;
  logic [INDEX_BITS-1:0]  w_index;
  logic [TAG_BITS-1:0]    w_tag;
  logic                   w_lookup_hit;
  logic [31:0]            w_word;
  logic                   w_fill_we;
  logic                   w_fill_done;
  logic                   w_store_we;

  logic                   w_hit;
  logic [31:0]            w_read_data;
  logic                   w_mem_read;
  logic                   w_mem_write;
  logic [31:0]            w_mem_address;
  logic [31:0]            w_mem_write_data;

  assign w_offset     = cache_bus.address[OFFSET_BITS+1:2];
  assign w_index      = cache_bus.address[OFFSET_BITS+INDEX_BITS+1:OFFSET_BITS+2];
  assign w_tag        = cache_bus.address[31:32-TAG_BITS];
  assign w_lookup_hit = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_word       = r_data[{w_index, w_offset}];

  always_comb begin
    w_next           = r_state;
    w_hit            = 1'b1;
    w_read_data      = '0;
    w_mem_read       = 1'b0;
    w_mem_write      = 1'b0;
    w_mem_address    = '0;
    w_mem_write_data = '0;
    w_fill_we        = 1'b0;
    w_fill_done      = 1'b0;
    w_store_we       = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Stores take priority over loads when both are asserted.
        if (cache_bus.MemWrite) begin
          w_hit  = 1'b0;
          w_next = S_WRITE;
        end else if (cache_bus.MemRead) begin
          if (w_lookup_hit) begin
            w_read_data = w_word;
          end else begin
            w_hit  = 1'b0;
            w_next = S_FILL;
          end
        end
      end
      S_FILL: begin
        w_hit         = 1'b0;
        w_mem_read    = 1'b1;
        w_mem_address = {w_tag, w_index, r_count, 2'b00};
        if (cache_bus.mem_ready) begin
          w_fill_we = 1'b1;
          if (&r_count) begin
            w_fill_done = 1'b1;
            w_next      = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        w_mem_write      = 1'b1;
        w_mem_address    = {cache_bus.address[31:2], 2'b00};
        w_mem_write_data = cache_bus.write_data;
        w_hit            = cache_bus.mem_ready;
        if (cache_bus.mem_ready) begin
          // No allocate: only a resident line picks up the store.
          w_store_we = w_lookup_hit;
          w_next     = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_next == S_FILL) begin
        r_count <= '0;
      end else if (w_fill_we) begin
        r_count <= r_count + 1'b1;
      end
      if (w_fill_done) begin
        r_valid[w_index] <= 1'b1;
      end
    end
  end

  // Tag and data arrays are deliberately not reset; the valid bits gate them.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (w_fill_we) begin
        r_data[{w_index, r_count}] <= cache_bus.mem_read_data;
      end
      if (w_fill_done) begin
        r_tag[w_index] <= w_tag;
      end
      if (w_store_we) begin
        r_data[{w_index, w_offset}] <= cache_bus.write_data;
      end
    end
  end

  assign cache_bus.hit            = w_hit;
  assign cache_bus.read_data      = w_read_data;
  assign cache_bus.mem_read       = w_mem_read;
  assign cache_bus.mem_write      = w_mem_write;
  assign cache_bus.mem_address    = w_mem_address;
  assign cache_bus.mem_write_data = w_mem_write_data;
  assign o_state                  = r_state;

endmodule

// File: tb/tb_data_cache_controller.sv
// Bench for data_cache_controller: access-level cache/memory model drives
// per-cycle expectations that a single negedge process compares.
module tb_data_cache_controller;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  data_cache_controller_if bus ();
  logic [1:0] dbg_state;

  data_cache_controller #(.INDEX_BITS(4), .OFFSET_BITS(2)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .cache_bus(bus),
    .o_state  (dbg_state)
  );

  // Model: cache contents plus main memory (written-through stores override addr+0x1000).
  logic        m_valid [16];
  logic [23:0] m_tag   [16];
  logic [31:0] m_data  [64];
  logic [31:0] mem_q   [logic [31:0]];

  int n_pass  = 0;
  int n_total = 0;

  logic        chk_en = 1'b0;
  logic        cur_access = 1'b0;
  logic        exp_hit, exp_mr, exp_mw;
  logic [31:0] exp_rd, exp_ma, exp_mwd;
  int          stall_cnt  = 0;
  int          last_stall = 0;
  logic [31:0] last_rd    = '0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (mem_q.exists(a)) return mem_q[a];
    return a + 32'h1000;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("hit",            32'(bus.hit),       32'(exp_hit));
      check("read_data",      bus.read_data,      exp_rd);
      check("mem_read",       32'(bus.mem_read),  32'(exp_mr));
      check("mem_write",      32'(bus.mem_write), 32'(exp_mw));
      check("mem_address",    bus.mem_address,    exp_ma);
      check("mem_write_data", bus.mem_write_data, exp_mwd);
      if (cur_access) begin
        if (bus.hit !== 1'b1) begin
          stall_cnt = stall_cnt + 1;
        end else begin
          last_stall = stall_cnt;
          last_rd    = bus.read_data;
          stall_cnt  = 0;
        end
      end
    end
  end

  // One cycle: apply inputs and the expectation for that cycle, then cross the edge.
  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic rdy, input logic [31:0] mrd,
                       input logic e_hit, input logic [31:0] e_rd, input logic e_mr,
                       input logic e_mw, input logic [31:0] e_ma, input logic [31:0] e_mwd);
    bus.MemRead       = rd;
    bus.MemWrite      = wr;
    bus.address       = a;
    bus.write_data    = wd;
    bus.mem_ready     = rdy;
    bus.mem_read_data = mrd;
    exp_hit = e_hit; exp_rd = e_rd; exp_mr = e_mr;
    exp_mw  = e_mw;  exp_ma = e_ma; exp_mwd = e_mwd;
    @(posedge clock);
    #1;
  endtask

  task automatic do_idle();
    drive(0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 32'h0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic do_load(input logic [31:0] a, input int wt);
    int idx, off;
    logic [23:0] tg;
    logic [31:0] base, wa;
    idx  = int'((a >> 4) & 32'hF);
    off  = int'((a >> 2) & 32'h3);
    tg   = a[31:8];
    base = a & 32'hFFFF_FFF0;
    cur_access = 1'b1;
    if (m_valid[idx] && m_tag[idx] == tg) begin
      drive(1, 0, a, 32'h0, 0, 32'h0, 1, m_data[idx*4+off], 0, 0, 32'h0, 32'h0);
    end else begin
      drive(1, 0, a, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
      for (int w = 0; w < 4; w++) begin
        wa = base + 32'(4 * w);
        repeat (wt) drive(1, 0, a, 32'h0, 0, 32'h0, 0, 32'h0, 1, 0, wa, 32'h0);
        drive(1, 0, a, 32'h0, 1, mem_val(wa), 0, 32'h0, 1, 0, wa, 32'h0);
        m_data[idx*4+w] = mem_val(wa);
      end
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      drive(1, 0, a, 32'h0, 0, 32'h0, 1, m_data[idx*4+off], 0, 0, 32'h0, 32'h0);
    end
    cur_access = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input int wt);
    int idx, off;
    logic [31:0] wa;
    idx = int'((a >> 4) & 32'hF);
    off = int'((a >> 2) & 32'h3);
    wa  = a & 32'hFFFF_FFFC;
    cur_access = 1'b1;
    drive(0, 1, a, d, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    repeat (wt) drive(0, 1, a, d, 0, 32'h0, 0, 32'h0, 0, 1, wa, d);
    drive(0, 1, a, d, 1, 32'h0, 1, 32'h0, 0, 1, wa, d);
    mem_q[wa] = d;
    if (m_valid[idx] && m_tag[idx] == a[31:8]) m_data[idx*4+off] = d;
    cur_access = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
    end
    for (int i = 0; i < 64; i++) m_data[i] = '0;
    bus.MemRead = 0; bus.MemWrite = 0; bus.address = 0; bus.write_data = 0;
    bus.mem_ready = 0; bus.mem_read_data = 0;
    exp_hit = 1; exp_rd = 0; exp_mr = 0; exp_mw = 0; exp_ma = 0; exp_mwd = 0;

    @(posedge clock);
    #1;
    reset_n = 1'b1;
    chk_en  = 1'b1;
    check("reset_state", 32'(dbg_state), 32'h0);
    do_idle();

    do_load(32'h0000_0010, 0);
    check("load10_stall", 32'(last_stall), 32'd5);
    check("load10_data",  last_rd, 32'h0000_1010);

    do_load(32'h0000_0014, 0);
    check("load14_stall", 32'(last_stall), 32'd0);
    check("load14_data",  last_rd, 32'h0000_1014);

    do_store(32'h0000_0014, 32'hDEAD_BEEF, 3);
    check("store14_stall", 32'(last_stall), 32'd4);

    do_load(32'h0000_0014, 0);
    check("load14_after_store", last_rd, 32'hDEAD_BEEF);
    check("load14_after_store_stall", 32'(last_stall), 32'd0);

    do_store(32'h0000_0200, 32'h1234_5678, 0);
    check("store200_stall", 32'(last_stall), 32'd1);
    do_load(32'h0000_0200, 0);
    check("load200_stall", 32'(last_stall), 32'd5);
    check("load200_data",  last_rd, 32'h1234_5678);

    do_load(32'h0000_0110, 1);
    check("load110_stall", 32'(last_stall), 32'd9);
    check("load110_data",  last_rd, 32'h0000_1110);
    do_load(32'h0000_0010, 0);
    check("reload10_stall", 32'(last_stall), 32'd5);
    check("reload10_data",  last_rd, 32'h0000_1010);
    do_idle();

    // Reset asserted while the second fill word of a miss is outstanding.
    drive(1, 0, 32'h310, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    drive(1, 0, 32'h310, 32'h0, 1, mem_val(32'h310), 0, 32'h0, 1, 0, 32'h310, 32'h0);
    reset_n = 1'b0;
    drive(1, 0, 32'h310, 32'h0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h314, 32'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    check("rst_mem_read", 32'(bus.mem_read), 32'h0);
    do_idle();

    do_load(32'h0000_0010, 0);
    check("post_reset_stall", 32'(last_stall), 32'd5);
    check("post_reset_data",  last_rd, 32'h0000_1010);
    do_load(32'h0000_001C, 0);
    check("load1c_data", last_rd, 32'h0000_101C);
    do_idle();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/data_cache_controller.md
# data_cache_controller

Direct-mapped, write-through, no-write-allocate data cache sitting between the EX/MEM pipeline register and main memory. It services the MEM-stage access (MemRead/MemWrite, address, store data) and drives the `hit` signal consumed by the EX/MEM pipeline register: `hit` = 1 lets the pipeline advance, `hit` = 0 stalls it. On a read miss it fills one block word-by-word from main memory. Every store is written through to memory before `hit` is released.

## Interface
- INDEX_BITS, 4, line index width (16 lines)
- OFFSET_BITS, 2, word-offset width (4 words/block); tag = 32-2-OFFSET_BITS-INDEX_BITS bits
- clock  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  synchronous, active-low reset
- MemRead  in  1  load request from EX/MEM stage
- MemWrite  in  1  store request from EX/MEM stage; has priority if both are high
- address  in  32  byte address (ALU_result); bits [1:0] ignored
- write_data  in  32  store data (read_data_2)
- read_data  out  32  load data; valid when MemRead & hit, else 0
- hit  out  1  1 = access complete / no stall; 0 = stall pipeline
- mem_read  out  1  block-fill word request to main memory
- mem_write  out  1  write-through request to main memory
- mem_address  out  32  word-aligned memory address
- mem_write_data  out  32  store data to memory
- mem_read_data  in  32  fill data, valid when mem_ready is high during a fill
- mem_ready  in  1  memory accepts/completes the current word this cycle

## Operation
- Address split: offset = address[OFFSET_BITS+1:2], index = next INDEX_BITS, tag = remaining upper bits.
- Storage: per line a valid bit, a tag, and 2^OFFSET_BITS data words. Lookup is combinational.
- FSM states:
  - IDLE: no memory request.
    - No access: hit=1.
    - MemRead with valid & tag match: hit=1, read_data=addressed word, stay IDLE.
    - MemRead miss: hit=0, go to FILL, word counter=0.
    - MemWrite: hit=0, go to WRITE.
  - FILL: mem_read=1, mem_address={tag,index,counter,2'b00}.
    - Each cycle with mem_ready=1, mem_read_data is written to word[counter] and the counter increments.
    - After the last word: set valid, write tag, go to IDLE. The re-lookup there hits.
    - hit=0 throughout FILL.
  - WRITE: mem_write=1, mem_address={address[31:2],2'b00}, mem_write_data=write_data, hit=mem_ready.
    - On mem_ready: if the line is valid and the tag matches, update the addressed word; go to IDLE.
    - On a miss, the cache is not modified (no allocate).
- Request outputs stay stable until mem_ready is sampled high. mem_ready is ignored in IDLE.
- The counter wraps to 0 after the last word.
- Read miss to a valid line with a different tag overwrites the whole line (eviction needs no writeback; the cache is write-through).
- Inputs must stay stable while hit=0. The pipeline register holds them.

## Timing
- Reset (reset_n low at an edge):
  - state=IDLE, counter=0, all valid bits cleared.
  - Outputs after that edge: hit=1 if no access, mem_read=0, mem_write=0, mem_address=0, mem_write_data=0, read_data=0.
  - Reset mid-FILL or mid-WRITE abandons the operation; the request drops the cycle after the reset edge. Data arrays are not cleared.
- Read hit: zero stall; read_data and hit are combinational in the same cycle.
- Read miss with mem_ready tied 1: 1 IDLE cycle + 4 FILL cycles of hit=0, then hit=1 on the 6th cycle. Each extra memory wait cycle adds 1.
- Store with mem_ready tied 1: hit=0 in the IDLE cycle, hit=1 in the single WRITE cycle (stall = 1). An N-cycle memory wait adds N.
- After the WRITE exit edge the pipeline has advanced. The next IDLE cycle sees the next instruction.

## Test plan
- Reset, then load 0x00000010. Memory model returns addr+0x1000 with ready=1.
  - Expect mem_address 0x10, 0x14, 0x18, 0x1C and hit=0 for 5 cycles.
  - Then hit=1 with read_data=0x00001010.
- Load 0x00000014 immediately after: hit=1 in the same cycle, read_data=0x00001014, mem_read stays 0.
- Store 0xDEADBEEF to 0x14 with mem_ready delayed 3 cycles:
  - Expect hit=0 for 4 cycles, with mem_write, mem_address=0x14 and mem_write_data held.
  - A following load of 0x14 returns 0xDEADBEEF with no memory traffic.
- Store to 0x00000200 (miss), then load 0x200: the store does not allocate, so the load misses and performs a 4-word fill starting at 0x200.
- Conflict test:
  - Load 0x00000110 (index 1, different tag from 0x10): miss, line evicted.
  - A following load of 0x10 misses again and refills.
- Drive reset_n low during the 2nd FILL word, then release:
  - Expect mem_read=0 the cycle after the reset edge.
  - A following load of 0x10 misses (valid bits cleared).
